// File: rtl/sb_pkg.sv
// Shared size encoding and byte-lane helpers for the writeback store buffer.
package sb_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_W = 2'b01;
  localparam logic [1:0] SZ_D = 2'b10;
  localparam logic [1:0] SZ_Q = 2'b11;

  typedef logic [1:0] sb_size_t;

  typedef struct packed {
    logic hit;
    logic conflict;
  } sb_lookup_t;

  function automatic logic [7:0] byte_mask(input logic [2:0] off, input sb_size_t size);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_W:    base = 8'h03;
      SZ_D:    base = 8'h0f;
      default: base = 8'hff;
    endcase
    return base << off;
  endfunction

  // True when the access spills past the end of its 8-byte granule.
  function automatic logic crosses(input logic [2:0] off, input sb_size_t size);
    logic [4:0] last;
    last = {2'b00, off} + (5'd1 << size);
    return last > 5'd8;
  endfunction
endpackage

// File: rtl/wb_store_buffer_if.sv
// Store buffer bus: writeback enqueue, dcache drain and load lookup signals.
interface wb_store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ENQ_V;
  logic [ADDR_W-1:0] ENQ_ADDR;
  logic [DATA_W-1:0] ENQ_DATA;
  logic [1:0]        ENQ_SIZE;
  logic              WB_stall;
  logic              DC_Write;
  logic [ADDR_W-1:0] DC_Address;
  logic [DATA_W-1:0] DC_Data;
  logic [1:0]        DC_Size;
  logic              DC_write_ready;
  logic              LD_V;
  logic [ADDR_W-1:0] LD_ADDR;
  logic [1:0]        LD_SIZE;
  logic              LD_Hit;
  logic [DATA_W-1:0] LD_Data;
  logic              LD_Conflict;
  logic              SB_Empty;
  logic [CNT_W-1:0]  SB_Count;

  modport master (
    output ENQ_V, ENQ_ADDR, ENQ_DATA, ENQ_SIZE, DC_write_ready, LD_V, LD_ADDR, LD_SIZE,
    input  WB_stall, DC_Write, DC_Address, DC_Data, DC_Size, LD_Hit, LD_Data, LD_Conflict,
           SB_Empty, SB_Count
  );

  modport slave (
    input  ENQ_V, ENQ_ADDR, ENQ_DATA, ENQ_SIZE, DC_write_ready, LD_V, LD_ADDR, LD_SIZE,
    output WB_stall, DC_Write, DC_Address, DC_Data, DC_Size, LD_Hit, LD_Data, LD_Conflict,
           SB_Empty, SB_Count
  );
endinterface

// File: rtl/sb_match.sv
// Load lookup: per-entry overlap/exact compare, youngest-first select walking back from tail.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0][1:0]        size,
  input  logic [PTR_W-1:0]             tail,
  input  logic                         ld_v,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [1:0]                   ld_size,
  output logic                         hit,
  output logic                         conflict,
  output logic [PTR_W-1:0]             sel
);
  logic [DEPTH-1:0] overlap;
  logic [DEPTH-1:0] exact;
  logic [7:0]       ld_mask;
  logic             found;
  logic [PTR_W-1:0] idx;
  sb_lookup_t       res;

  assign ld_mask = byte_mask(ld_addr[2:0], ld_size);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign overlap[i] = valid[i] && (addr[i][ADDR_W-1:3] == ld_addr[ADDR_W-1:3])
                        && |(byte_mask(addr[i][2:0], size[i]) & ld_mask);
    assign exact[i]   = valid[i] && (addr[i] == ld_addr) && (size[i] == ld_size);
  end

  // tail-1 is the youngest entry; when full, tail==head so the walk still covers every slot.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!found && overlap[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    res.hit      = ld_v && found && exact[sel];
    res.conflict = ld_v && found && !res.hit;
  end

  assign hit      = res.hit;
  assign conflict = res.conflict;
endmodule

// File: rtl/wb_store_buffer.sv
// Post-writeback store buffer: in-order FIFO to the dcache with store-to-load forwarding.
module wb_store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic CLK,
  input logic CLR,
  wb_store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]             head, tail;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;
  logic [DEPTH-1:0][1:0]        e_size;

  logic             full, enq, deq;
  logic             hit, conflict;
  logic [PTR_W-1:0] sel;

  assign full = (count == CNT_W'(DEPTH));
  // A full buffer never takes the incoming store, even if the head leaves this cycle.
  assign enq  = sb.ENQ_V && !full;
  assign deq  = valid[head] && sb.DC_write_ready;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_size[i] <= '0;
      end
    end else begin
      if (enq) begin
        valid[tail]  <= 1'b1;
        e_addr[tail] <= sb.ENQ_ADDR;
        e_data[tail] <= sb.ENQ_DATA;
        e_size[tail] <= sb.ENQ_SIZE;
        tail         <= tail + PTR_W'(1);
      end
      if (deq) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      assert (!(sb.ENQ_V && crosses(sb.ENQ_ADDR[2:0], sb.ENQ_SIZE)));
      assert (!(sb.LD_V && crosses(sb.LD_ADDR[2:0], sb.LD_SIZE)));
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid    (valid),
    .addr     (e_addr),
    .size     (e_size),
    .tail     (tail),
    .ld_v     (sb.LD_V),
    .ld_addr  (sb.LD_ADDR),
    .ld_size  (sb.LD_SIZE),
    .hit      (hit),
    .conflict (conflict),
    .sel      (sel)
  );

  assign sb.WB_stall    = sb.ENQ_V && full;
  assign sb.DC_Write    = valid[head];
  assign sb.DC_Address  = e_addr[head];
  assign sb.DC_Data     = e_data[head];
  assign sb.DC_Size     = e_size[head];
  assign sb.LD_Hit      = hit;
  assign sb.LD_Data     = hit ? e_data[sel] : '0;
  assign sb.LD_Conflict = conflict;
  assign sb.SB_Empty    = (count == '0);
  assign sb.SB_Count    = count;
endmodule
